// File: rtl/cache_back_end_native.sv
// ---------------------------------------------------------------------------
// cache_back_end_native
//
// Memory-side initiator of the cache. It turns line-replacement requests
// and write-through buffer entries into native valid/ready memory
// transactions. A line fill is issued as 2^LINE_W sequential single-word
// reads. Each write-buffer entry is issued as one single-word write.
// Writes always take priority over fills.
//
// Optional feature macro: CACHE_BE_WRITE_BURST_EN
//   defined   : WRITE stays resident while buffer entries remain, so
//               consecutive writes go out back to back.
//   undefined : the FSM returns to IDLE after every completed write.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   replace_valid/addr   line fill request and line address from the cache
//   replace              high while a fill is in progress
//   read_valid/addr/data returned fill word, its index in the line, its data
//   write_valid/addr/    head entry of the write-through buffer
//   write_wdata/wstrb
//   write_ready          pop strobe for the write buffer
//   mem_*                native memory port (valid/ready, wstrb==0 is a read)
// ---------------------------------------------------------------------------
module cache_back_end_native #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NBYTES = DATA_W / 8,
  parameter int BYTE_W = $clog2(NBYTES),
  parameter int LINE_W = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             replace_valid,
  input  logic [ADDR_W-BYTE_W-LINE_W-1:0]  replace_addr,
  output logic                             replace,
  output logic                             read_valid,
  output logic [LINE_W-1:0]                read_addr,
  output logic [DATA_W-1:0]                read_data,
  input  logic                             write_valid,
  input  logic [ADDR_W-BYTE_W-1:0]         write_addr,
  input  logic [DATA_W-1:0]                write_wdata,
  input  logic [NBYTES-1:0]                write_wstrb,
  output logic                             write_ready,
  output logic                             mem_valid,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  output logic [NBYTES-1:0]                mem_wstrb,
  input  logic [DATA_W-1:0]                mem_rdata,
  input  logic                             mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [LINE_W-1:0]               count_q, count_d;
  logic [ADDR_W-BYTE_W-LINE_W-1:0] line_addr_q, line_addr_d;

  // State register: FSM state, word counter within the current fill and the
  // line address latched when the fill was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      line_addr_q <= line_addr_d;
    end
  end

  // Next-state and output logic. Every output defaults to zero so that IDLE
  // presents a quiet memory port and the reset values fall out naturally.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    line_addr_d = line_addr_q;
    replace     = 1'b0;
    read_valid  = 1'b0;
    read_addr   = '0;
    read_data   = '0;
    write_ready = 1'b0;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;

    case (state_q)
      S_IDLE: begin
        // Draining the write buffer first keeps a fill from reading stale
        // memory behind a pending write-through.
        if (write_valid) begin
          state_d = S_WRITE;
        end else if (replace_valid) begin
          state_d     = S_READ;
          line_addr_d = replace_addr;
          count_d     = '0;
        end
      end

      S_WRITE: begin
        // Request fields come straight from the buffer head, which the
        // buffer holds stable until it is popped.
        mem_addr  = {write_addr, {BYTE_W{1'b0}}};
        mem_wdata = write_wdata;
        mem_wstrb = write_wstrb;
`ifdef CACHE_BE_WRITE_BURST_EN
        mem_valid   = write_valid;
        write_ready = write_valid & mem_ready;
        if (!write_valid) begin
          state_d = S_IDLE;
        end
`else
        mem_valid   = 1'b1;
        write_ready = mem_ready;
        if (mem_ready) begin
          state_d = S_IDLE;
        end
`endif
      end

      S_READ: begin
        replace   = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = {line_addr_q, count_q, {BYTE_W{1'b0}}};
        if (mem_ready) begin
          read_valid = 1'b1;
          read_addr  = count_q;
          read_data  = mem_rdata;
          // The counter wraps to zero on the last word, ready for the next fill.
          count_d    = count_q + 1'b1;
          if (count_q == {LINE_W{1'b1}}) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_back_end_native.sv
// ---------------------------------------------------------------------------
// tb_cache_back_end_native
//
// Self-checking bench for cache_back_end_native with default parameters
// (32-bit address/data, 4-word lines). The bench plays both the cache (a
// write-buffer queue plus a held fill request) and the memory (random ready
// and read data). A transaction-level model predicts the port behaviour each
// cycle from the buffer contents and the fill progress, and a set of directed
// sequences pins the model with hand-computed literal values.
// Honours CACHE_BE_WRITE_BURST_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_cache_back_end_native;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NBYTES = 4;
  localparam int LINE_W = 2;
  localparam int WORDS  = 4;
  localparam int LA_W   = ADDR_W - 2 - LINE_W;

  localparam int OP_IDLE  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_FILL  = 2;

  typedef struct {
    logic [ADDR_W-3:0] addr;
    logic [DATA_W-1:0] data;
    logic [NBYTES-1:0] strb;
  } wentry_t;

  logic                clk;
  logic                reset;
  logic                replace_valid;
  logic [LA_W-1:0]     replace_addr;
  logic                replace;
  logic                read_valid;
  logic [LINE_W-1:0]   read_addr;
  logic [DATA_W-1:0]   read_data;
  logic                write_valid;
  logic [ADDR_W-3:0]   write_addr;
  logic [DATA_W-1:0]   write_wdata;
  logic [NBYTES-1:0]   write_wstrb;
  logic                write_ready;
  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NBYTES-1:0]   mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ready;

  // Cache-side and memory-side stimulus state.
  wentry_t         wbuf[$];
  logic            fill_req;
  logic [LA_W-1:0] fill_addr;
  logic            rdy;
  logic [31:0]     rdata;
  logic            rst;

  // Behavioural model state.
  bit              m_known;
  int              m_op;
  logic [LA_W-1:0] m_line;
  int              m_word;

  int n_cmp;
  int n_fail;

  cache_back_end_native dut (
    .clk           (clk),
    .reset         (reset),
    .replace_valid (replace_valid),
    .replace_addr  (replace_addr),
    .replace       (replace),
    .read_valid    (read_valid),
    .read_addr     (read_addr),
    .read_data     (read_data),
    .write_valid   (write_valid),
    .write_addr    (write_addr),
    .write_wdata   (write_wdata),
    .write_wstrb   (write_wstrb),
    .write_ready   (write_ready),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present the cache and memory state on the DUT inputs.
  task automatic drive();
    reset         = rst;
    write_valid   = (wbuf.size() != 0);
    write_addr    = (wbuf.size() != 0) ? wbuf[0].addr : '0;
    write_wdata   = (wbuf.size() != 0) ? wbuf[0].data : '0;
    write_wstrb   = (wbuf.size() != 0) ? wbuf[0].strb : '0;
    replace_valid = fill_req;
    replace_addr  = fill_addr;
    mem_ready     = rdy;
    mem_rdata     = rdata;
  endtask

  task automatic push_write(input logic [ADDR_W-3:0] a, input logic [31:0] d, input logic [3:0] s);
    wentry_t e;
    e.addr = a;
    e.data = d;
    e.strb = s;
    wbuf.push_back(e);
  endtask

  // Random cache and memory behaviour. A fill request, once raised, is held
  // unchanged until its last word has been returned.
  task automatic applyStimulus();
    if (wbuf.size() < 4 && $urandom_range(0, 5) == 0)
      push_write(30'($urandom), $urandom, 4'($urandom_range(1, 15)));
    if (!fill_req && $urandom_range(0, 4) == 0) begin
      fill_req  = 1'b1;
      fill_addr = LA_W'($urandom);
    end
    rdy   = ($urandom_range(0, 99) < 60);
    rdata = $urandom;
    rst   = ($urandom_range(0, 249) == 0);
    drive();
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the
  // model (and the cache state it owns) across the coming clock edge.
  task automatic checkOutput();
    logic        e_valid, e_replace, e_rvalid, e_wready;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_raddr;
    e_valid = 1'b0; e_replace = 1'b0; e_rvalid = 1'b0; e_wready = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_wstrb = '0; e_raddr = '0;

    if (!m_known) begin
      if (reset) begin
        m_known = 1'b1;
        m_op    = OP_IDLE;
      end
      return;
    end

    if (m_op == OP_WRITE) begin
`ifdef CACHE_BE_WRITE_BURST_EN
      e_valid = (wbuf.size() != 0);
`else
      e_valid = 1'b1;
`endif
      if (wbuf.size() != 0) begin
        e_addr  = 32'(longint'(wbuf[0].addr) * NBYTES);
        e_wdata = wbuf[0].data;
        e_wstrb = wbuf[0].strb;
      end
      e_wready = e_valid && mem_ready;
    end else if (m_op == OP_FILL) begin
      e_replace = 1'b1;
      e_valid   = 1'b1;
      e_addr    = 32'((longint'(m_line) * WORDS + m_word) * NBYTES);
      if (mem_ready) begin
        e_rvalid = 1'b1;
        e_raddr  = 2'(m_word);
        e_rdata  = mem_rdata;
      end
    end

    check("mem_valid", mem_valid, e_valid);
    check("replace", replace, e_replace);
    check("read_valid", read_valid, e_rvalid);
    check("write_ready", write_ready, e_wready);
    if (e_valid) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata_or_wstrb", {mem_wdata, mem_wstrb}, {e_wdata, e_wstrb});
    end
    if (m_op == OP_IDLE) check("idle_wstrb", mem_wstrb, 0);
    if (e_rvalid) begin
      check("read_addr", read_addr, e_raddr);
      check("read_data", read_data, e_rdata);
    end

    if (reset) begin
      m_op = OP_IDLE;
    end else if (m_op == OP_IDLE) begin
      if (wbuf.size() != 0) begin
        m_op = OP_WRITE;
      end else if (fill_req) begin
        m_op   = OP_FILL;
        m_line = fill_addr;
        m_word = 0;
      end
    end else if (m_op == OP_WRITE) begin
      if (e_wready) wbuf.delete(0);
`ifdef CACHE_BE_WRITE_BURST_EN
      if (!e_valid) m_op = OP_IDLE;
`else
      if (e_wready) m_op = OP_IDLE;
`endif
    end else begin
      if (mem_ready) begin
        m_word++;
        if (m_word == WORDS) begin
          m_op     = OP_IDLE;
          fill_req = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run with a ready memory until all pending work has finished.
  task automatic drain();
    int n;
    n   = 0;
    rst = 1'b0;
    rdy = 1'b1;
    while ((m_op != OP_IDLE || wbuf.size() != 0 || fill_req) && n < 200) begin
      rdata = $urandom;
      drive();
      tick();
      step();
      n++;
    end
    check("drain_within_bound", (n < 200), 1);
  endtask

  // Directed sequences pinning the model, then a long randomized run.
  initial begin
    int rv_cnt, hold_cnt, first_rd;
    int wr_cyc[$];
    n_cmp = 0; n_fail = 0;
    m_known = 1'b0; m_op = OP_IDLE; m_line = '0; m_word = 0;
    fill_req = 1'b0; fill_addr = '0; rdy = 1'b1; rdata = '0;

    // Reset with both requests pending: outputs quiet, write issues first.
    rst = 1'b1; fill_req = 1'b1; fill_addr = 28'h5;
    push_write(30'h11, 32'h1111_2222, 4'hF);
    drive(); tick(); step();
    drive(); tick();
    check("rst_quiet", {replace, read_valid, write_ready, mem_valid}, 0);
    check("rst_zero_buses", {mem_addr, mem_wdata, mem_wstrb, read_data, read_addr}, 0);
    step();
    rst = 1'b0; drive(); tick();
    check("rst_release_valid", mem_valid, 0);
    step();
    drive(); tick();
    check("first_valid", mem_valid, 1);
    check("first_is_write", mem_addr, 32'h44);
    step();
    drain();

    // Zero-wait fill of line 0x10.
    fill_req = 1'b1; fill_addr = 28'h10; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdata = 32'hA0 + i - 1;
      drive(); tick();
      if (i >= 1 && i <= 4) begin
        check("fill_addr", mem_addr, 32'h100 + 4 * (i - 1));
        check("fill_rvalid", read_valid, 1);
        check("fill_raddr", read_addr, i - 1);
        check("fill_rdata", read_data, 32'hA0 + i - 1);
      end
      if (i == 5) check("fill_replace_falls", replace, 0);
      step();
    end
    drain();

    // Fill stalled for three cycles on word 2.
    fill_req = 1'b1; fill_addr = 28'h20;
    rv_cnt = 0; hold_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      rdy   = !(i >= 3 && i <= 5);
      rdata = $urandom;
      drive(); tick();
      if (read_valid) rv_cnt++;
      if (mem_valid && mem_addr == 32'h208) hold_cnt++;
      if (i >= 3 && i <= 5) check("stall_no_rvalid", read_valid, 0);
      step();
    end
    check("stall_hold_cycles", hold_cnt, 4);
    check("stall_rvalid_pulses", rv_cnt, 4);
    drain();

    // Single write with two wait cycles.
    push_write(30'h40, 32'hDEAD_BEEF, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      rdy = (i == 3);
      drive(); tick();
      if (i >= 1 && i <= 3) begin
        check("wr_addr", mem_addr, 32'h100);
        check("wr_strb", mem_wstrb, 4'b0011);
        check("wr_data", mem_wdata, 32'hDEAD_BEEF);
      end
      check("wr_pop", write_ready, (i == 3));
      step();
    end
    drain();

    // Two buffered writes and a fill requested together.
    push_write(30'h50, 32'h5050_5050, 4'hF);
    push_write(30'h51, 32'h5151_5151, 4'hC);
    fill_req = 1'b1; fill_addr = 28'h40; rdy = 1'b1;
    first_rd = -1;
    for (int i = 0; i < 7; i++) begin
      rdata = $urandom;
      drive(); tick();
      if (write_ready) wr_cyc.push_back(i);
      if (first_rd < 0 && read_valid) begin
        first_rd = i;
        check("prio_read_addr", mem_addr, 32'h400);
      end
      step();
    end
    check("prio_pops", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
`ifdef CACHE_BE_WRITE_BURST_EN
      check("prio_write_gap", wr_cyc[1] - wr_cyc[0], 1);
`else
      check("prio_write_gap", wr_cyc[1] - wr_cyc[0], 2);
`endif
    end
    check("prio_first_read", first_rd, 5);
    drain();

    // Reset during word 1 of a fill, then restart from word 0.
    fill_req = 1'b1; fill_addr = 28'h30; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rst   = (i == 2);
      rdata = $urandom;
      drive(); tick();
      if (i == 3) check("midrst_quiet", {mem_valid, replace}, 0);
      if (i == 4) begin
        check("midrst_restart_addr", mem_addr, 32'h300);
        check("midrst_restart_word", read_addr, 0);
      end
      step();
    end
    drain();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
      tick();
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_back_end_native.md
Name: cache_back_end_native

Overview:
- Memory-side initiator of the cache. It turns cache-internal line-replacement requests and write-through buffer entries into native valid/ready transactions toward main memory.
- Sits between the cache core (tag/data memories, write-through buffer) and the external memory port. It is the counterpart of the CPU-facing responder front end.
- Line fills are issued as sequential single-word reads. Write-buffer entries are issued as single-word writes.

Parameters:
ADDR_W, 32, byte-address width of the memory port
DATA_W, 32, word width of the cache and memory port
NBYTES, DATA_W/8, bytes per word (derived, do not override)
BYTE_W, $clog2(NBYTES), byte-offset bits (derived)
LINE_W, 2, log2(words per line); legal range >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
replace_valid  input  1  cache requests a line fill
replace_addr  input  ADDR_W-BYTE_W-LINE_W  line address of the fill
replace  output  1  fill in progress
read_valid  output  1  one returned fill word valid this cycle
read_addr  output  LINE_W  word index within the line of read_data
read_data  output  DATA_W  returned fill word
write_valid  input  1  write buffer non-empty; head entry presented
write_addr  input  ADDR_W-BYTE_W  word address of head entry
write_wdata  input  DATA_W  head entry data
write_wstrb  input  NBYTES  head entry byte strobes (non-zero)
write_ready  output  1  pop strobe for the write buffer
mem_valid  output  1  memory request valid
mem_addr  output  ADDR_W  byte address; low BYTE_W bits always 0
mem_wdata  output  DATA_W  write data
mem_wstrb  output  NBYTES  byte strobes; all zero means read
mem_rdata  input  DATA_W  read data, valid when mem_ready=1
mem_ready  input  1  transfer complete this cycle

Behaviour:
- Clock and reset: clk only; reset is synchronous and active-high.
- Reset values: FSM=IDLE, word counter=0, latched line address=0. All outputs are 0: replace, read_valid, read_addr, read_data, write_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb.
- Native handshake:
  - A transfer completes in the cycle where mem_valid=1 and mem_ready=1.
  - While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wstrb are held stable.
  - mem_ready may arrive in the same cycle mem_valid rises (zero-wait memory).
- FSM states:
  - IDLE:
    - write_valid=1 -> WRITE. Write has priority for write-through coherency.
    - Else replace_valid=1 -> READ. Latch replace_addr; counter=0.
    - A replace_valid that arrives while write_valid=1 waits in IDLE until the buffer drains. The cache holds replace_valid high.
  - WRITE:
    - mem_valid=1, mem_addr={write_addr,BYTE_W'b0}, mem_wdata=write_wdata, mem_wstrb=write_wstrb, all combinational from the buffer head.
    - write_ready=mem_ready, a one-cycle pop per completed transfer.
    - On completion -> IDLE (see Optional Feature).
  - READ:
    - replace=1 for the whole state. mem_valid=1, mem_wstrb=0.
    - mem_addr={line_addr,counter,BYTE_W'b0}.
    - On each mem_ready: read_valid=1, read_addr=counter, read_data=mem_rdata (same-cycle passthrough), counter+1.
    - On the last word (counter=2^LINE_W-1): counter wraps to 0 and FSM -> IDLE. replace falls in the next cycle.
- Outside READ, read_valid=0. Outside WRITE, write_ready=0. In IDLE, mem_valid=0 and mem_wstrb=0.
- Back-to-back fills: a new fill is accepted no earlier than the cycle after replace falls. There is at least one IDLE cycle between fills.
- Reset mid-transfer: abandon the operation and go to IDLE; mem_valid=0 from the next cycle. No pop is issued for an incomplete write.
- replace_valid in READ is ignored; the cache must not change it while replace=1.

Optional Feature:
CACHE_BE_WRITE_BURST_EN
- Defined: WRITE stays resident while entries remain.
  - In WRITE, mem_valid=write_valid.
  - After a pop, if write_valid is 1 the next cycle, the next entry is issued immediately with no IDLE gap.
  - FSM -> IDLE only in a cycle where write_valid=0.
- Undefined: after every completed write, FSM returns to IDLE, giving at least one cycle with mem_valid=0 between consecutive writes.

Test Plan:
1. Reset for 2 cycles with replace_valid=1 and write_valid=1 -> all outputs 0 during reset; first mem_valid appears in the cycle after reset falls.
2. replace_valid=1, replace_addr=0x0000_0010 (LINE_W=2, 32-bit), zero-wait memory returning 0xA0..0xA3 -> mem_addr 0x100,0x104,0x108,0x10C; read_valid for 4 cycles with read_addr 0..3 and read_data 0xA0..0xA3; replace falls on the following cycle.
3. Fill with mem_ready stalled 3 cycles on word 2 -> mem_addr held at 0x108 for 4 cycles; read_valid=0 during the stall; exactly 4 read_valid pulses total.
4. write_valid=1, write_addr=0x40, wdata=0xDEADBEEF, wstrb=4'b0011, mem_ready after 2 cycles -> mem_addr=0x100, mem_wstrb=0011, write_ready single pulse coincident with mem_ready.
5. replace_valid and write_valid both asserted with 2 buffered writes -> both writes are issued and popped before the first read address appears. With CACHE_BE_WRITE_BURST_EN there is no gap between the writes; without it there is one IDLE cycle.
6. Reset asserted during word 1 of a fill -> mem_valid=0 and replace=0 the next cycle; a new fill afterwards restarts at word 0.
